// File: rtl/pipeline_sequencer_if.sv
// Signal bundle between the pipeline datapath (master) and the stall/flush sequencer (slave).
interface pipeline_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic             id_fp_src;
   logic             id_is_multi;
   logic             redirect;
   logic             ex_reg_we;
   logic             ex_fp_dest;
   logic [1:0]       ex_din_src;
   logic [4:0]       ex_rd;
   logic             mem_reg_we;
   logic             mem_fp_dest;
   logic [4:0]       mem_rd;
   logic             cnt_clr;
   logic             pc_we;
   logic             ifid_we;
   logic             idex_we;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             multi_busy;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_fp_src, id_is_multi,
             redirect, ex_reg_we, ex_fp_dest, ex_din_src, ex_rd, mem_reg_we, mem_fp_dest,
             mem_rd, cnt_clr,
      input  pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_flush, multi_busy,
             stall_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_fp_src, id_is_multi,
             redirect, ex_reg_we, ex_fp_dest, ex_din_src, ex_rd, mem_reg_we, mem_fp_dest,
             mem_rd, cnt_clr,
      output pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_flush, multi_busy,
             stall_count
   );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the five-stage pipeline: hazard stalls, multi-cycle FPU hold, redirect squash.
// Define FWD_EN when forwarding paths exist (only load-use then stalls).
module pipeline_sequencer #(
   parameter int MULT_LATENCY = 5,
   parameter int CNT_W        = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   pipeline_sequencer_if.slave sif
);
   localparam int MC_W = $clog2(MULT_LATENCY + 1);
   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] MULTI = 1'b1;

   logic [0:0]       state_reg, state_next;
   logic [MC_W-1:0]  mcnt_reg, mcnt_next;
   logic [CNT_W-1:0] stall_reg, stall_next;
   logic             match_ex, match_mem, load_use, hazard;

   // Integer r0 is hardwired zero and never a dependency; FP f0 is a real register.
   function automatic logic match(input logic valid, input logic fp_src, input logic we,
                                  input logic fp_dest, input logic [4:0] rd,
                                  input logic [4:0] src, input logic used);
      return valid && we && used && (rd == src) && (fp_dest == fp_src) &&
             (fp_dest || (rd != 5'd0));
   endfunction

   always_comb begin
      match_ex  = match(sif.id_valid, sif.id_fp_src, sif.ex_reg_we, sif.ex_fp_dest, sif.ex_rd,
                        sif.id_rs1, sif.id_uses_rs1) ||
                  match(sif.id_valid, sif.id_fp_src, sif.ex_reg_we, sif.ex_fp_dest, sif.ex_rd,
                        sif.id_rs2, sif.id_uses_rs2);
      match_mem = match(sif.id_valid, sif.id_fp_src, sif.mem_reg_we, sif.mem_fp_dest, sif.mem_rd,
                        sif.id_rs1, sif.id_uses_rs1) ||
                  match(sif.id_valid, sif.id_fp_src, sif.mem_reg_we, sif.mem_fp_dest, sif.mem_rd,
                        sif.id_rs2, sif.id_uses_rs2);
      load_use  = match_ex && (sif.ex_din_src == 2'b01);
`ifdef FWD_EN
      hazard    = load_use;
`else
      hazard    = match_ex || match_mem;
`endif
   end

   always_comb begin
      sif.pc_we       = 1'b1;
      sif.ifid_we     = 1'b1;
      sif.idex_we     = 1'b1;
      sif.ifid_flush  = 1'b0;
      sif.idex_flush  = 1'b0;
      sif.exmem_flush = 1'b0;
      sif.multi_busy  = 1'b0;
      state_next      = state_reg;
      mcnt_next       = mcnt_reg;
      if (!rst_n) begin
         sif.pc_we       = 1'b0;
         sif.ifid_we     = 1'b0;
         sif.idex_we     = 1'b0;
         sif.ifid_flush  = 1'b1;
         sif.idex_flush  = 1'b1;
         sif.exmem_flush = 1'b1;
      end else if (state_reg == MULTI) begin
         sif.pc_we       = 1'b0;
         sif.ifid_we     = 1'b0;
         sif.idex_we     = 1'b0;
         sif.exmem_flush = 1'b1;
         sif.multi_busy  = 1'b1;
         mcnt_next       = mcnt_reg - 1'b1;
         if (mcnt_reg == MC_W'(1))
            state_next = RUN;
      end else if (hazard) begin
         sif.pc_we      = 1'b0;
         sif.ifid_we    = 1'b0;
         sif.idex_flush = 1'b1;
      end else if (sif.id_valid && sif.id_is_multi) begin
         // Issue proceeds as normal flow; a same-cycle redirect is dropped and re-presented later.
         state_next = MULTI;
         mcnt_next  = MC_W'(MULT_LATENCY - 1);
      end else if (sif.redirect) begin
         sif.ifid_flush = 1'b1;
      end
   end

   always_comb begin
      stall_next = stall_reg;
      if (sif.cnt_clr)
         stall_next = '0;
      else if (!sif.pc_we && (stall_reg != {CNT_W{1'b1}}))
         stall_next = stall_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
         mcnt_reg  <= '0;
         stall_reg <= '0;
      end else begin
         state_reg <= state_next;
         mcnt_reg  <= mcnt_next;
         stall_reg <= stall_next;
      end
   end

   assign sif.stall_count = stall_reg;
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush sequencer for the five-stage pipeline. It takes the ID-stage instruction's source operands and the EX/MEM destination fields, all produced by the Control decoder and carried in the pipeline registers. From these it drives the write-enables and flushes of the PC and the IF/ID, ID/EX and EX/MEM registers. It resolves load-use and RAW hazards, holds EX while a multi-cycle FPU operation occupies it, squashes wrong-path fetches on redirect, and counts stall cycles for performance monitoring.

## Interface
- MULT_LATENCY, 5: cycles a multi-cycle FPU op occupies EX; legal range 2..16.
- CNT_W, 16: width of the stall-cycle counter.

- Clk  in  1  clock, all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- IdValid  in  1  ID holds a real instruction.
- IdRs1, IdRs2  in  [0:4]  ID source register numbers.
- IdUsesRs1, IdUsesRs2  in  1  source actually read.
- IdFPSrc  in  1  sources are FP registers.
- IdIsMulti  in  1  ID instruction is a multi-cycle FPU op.
- Redirect  in  1  ID resolved a taken branch or jump.
- ExRegWE, ExFPDest  in  1  EX instruction writes a register, and whether it is FP.
- ExDInSrc  in  [0:1]  EX writeback source; 2'b01 means load.
- ExRd  in  [0:4]  EX destination.
- MemRegWE, MemFPDest  in  1  MEM instruction writes a register, and whether it is FP.
- MemRd  in  [0:4]  MEM destination.
- PCWE, IFIDWE, IDEXWE  out  1  register write enables.
- IFIDFlush, IDEXFlush, EXMEMFlush  out  1  insert bubble into the named register.
- MultiBusy  out  1  FSM in MULTI.
- StallCount  out  [CNT_W-1:0]  saturating count of cycles with PCWE=0.
- CntClr  in  1  synchronous clear of StallCount.

## Operation
- Match(stage, src) is true when all of the following hold: IdValid, stage RegWE, src used, stage Rd == src, and stage FPDest == IdFPSrc. Integer register 0 never matches; FP register 0 does.
- LoadUse is true when Match(EX) holds and ExDInSrc == 2'b01.
- FSM states are RUN and MULTI. The FSM resets to RUN.
- RUN priority, highest first:
  1. Hazard stall: PCWE=0, IFIDWE=0, IDEXFlush=1, IDEXWE=1. Redirect is ignored this cycle.
  2. Multi issue, when IdValid && IdIsMulti: outputs as for normal flow. Next state is MULTI, with counter loaded to MULTI_LATENCY-1.
  3. Redirect: IFIDFlush=1. PC and the other registers advance.
  4. Normal flow: all WE=1, all flush=0.
- MULTI: PCWE=IFIDWE=IDEXWE=0 and EXMEMFlush=1. The counter decrements each cycle. When the counter is 1, next state is RUN, so EX advances on the following cycle. Hazard and Redirect inputs are ignored in MULTI.
- StallCount increments on every cycle with PCWE=0 and saturates at all-ones. CntClr has priority over increment.

## Timing
- Reset, while Rst_n=0:
  - PCWE=IFIDWE=IDEXWE=0; IFIDFlush=IDEXFlush=EXMEMFlush=1; MultiBusy=0.
  - StallCount=0; state RUN; counter 0.
- Reset asserted mid-MULTI aborts the op. After release the FSM starts in RUN.
- Hazard outputs are combinational from inputs and state, so a stall takes effect at the same edge.
- A load-use stall lasts exactly 1 cycle with forwarding. A multi op stalls for MULT_LATENCY-1 cycles after the issue cycle.
- If a multi op issues with Redirect asserted in the same cycle, multi issue wins; Redirect must be re-presented by the ID stage.

## Configuration
- FWD_EN defined: forwarding paths exist. The only hazard is LoadUse.
- FWD_EN undefined: the hazard is Match(EX) || Match(MEM). A RAW hazard stalls up to 2 cycles, re-evaluated each cycle.

## Test plan
- Load r3 in EX (ExDInSrc=01, ExRd=3), ID reads r3 -> exactly 1 cycle with PCWE=0 and IDEXFlush=1, then normal flow; StallCount=1.
- ExRd=0, integer, load, ID reads r0 -> no stall. Same case with FP and IdFPSrc=1 -> stall.
- IdIsMulti with MULT_LATENCY=5 -> MultiBusy high for 4 cycles with EXMEMFlush=1 and PCWE=0, then RUN; StallCount=4.
- Redirect with no hazard -> IFIDFlush=1 for one cycle, PCWE=1. Redirect with load-use -> IFIDFlush=0, stall only.
- Rst_n low in the 2nd MULTI cycle -> all WE=0 and flushes=1 immediately; after release, state RUN and StallCount=0.
- FWD_EN undefined, MemRd=7 with MemRegWE=1, ID reads r7 -> 1-cycle stall. FWD_EN defined, same stimulus -> no stall. Preload StallCount=all-ones -> it holds.
